// File: rtl/tri_fill_if.sv
// Host-side bus of the triangular fill array: fill control, host write port and read port.
// The master drives requests and addresses; the slave (the array) returns status and data.
interface tri_fill_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 16,
  parameter int COLS  = 16
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int AR = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AC = (COLS > 1) ? $clog2(COLS) : 1;

  logic             start;
  logic [RW-1:0]    row_lim;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] and_out;

  logic             wr_en;
  logic [AR-1:0]    wr_row;
  logic [AC-1:0]    wr_col;
  logic [WIDTH-1:0] wr_data;
  logic             wr_err;

  logic [AR-1:0]    rd_row;
  logic [AC-1:0]    rd_col;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, row_lim, lo_val, hi_val, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col,
    input  busy, done, and_out, wr_err, rd_data
  );

  modport slave (
    input  start, row_lim, lo_val, hi_val, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col,
    output busy, done, and_out, wr_err, rd_data
  );
endinterface

// File: rtl/tri_fill_array.sv
// ROWS x COLS word array with a one-word-per-cycle triangular fill engine
// (lower triangle first, then upper), a host write port usable while idle and a registered read port.
module tri_fill_array #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 16,
  parameter int COLS  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  tri_fill_if.slave    bus
);

  // One index width wide enough for row/column counters and the clamped row limit.
  localparam int IW = $clog2(((ROWS > COLS) ? ROWS : COLS) + 1);
  localparam logic [IW-1:0] ROWS_I  = IW'(ROWS);
  localparam logic [IW-1:0] COLS_I  = IW'(COLS);
  localparam logic [IW-1:0] COLS_M1 = IW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, FILL_LO, FILL_HI, DONE} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;
  logic [IW-1:0]    lim_q, lim_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] and_q, and_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_err_q, wr_err_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic [WIDTH-1:0] mem_q [ROWS][COLS];

  logic [IW-1:0]    lim_cap;
  logic [IW-1:0]    j_max;
  logic             host_ok;
  logic             fill_we;
  logic [WIDTH-1:0] fill_val;
  logic             mem_we;
  logic [IW-1:0]    mem_row;
  logic [IW-1:0]    mem_col;
  logic [WIDTH-1:0] mem_wdata;

  assign lim_cap = (IW'(bus.row_lim) > ROWS_I) ? ROWS_I : IW'(bus.row_lim);
  assign j_max   = (i_q < COLS_M1) ? i_q : COLS_M1;
  assign host_ok = (state_q == IDLE) && (IW'(bus.wr_row) < ROWS_I) && (IW'(bus.wr_col) < COLS_I);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    lim_d    = lim_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    and_d    = and_q;
    fill_we  = 1'b0;
    fill_val = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lim_d   = lim_cap;
          lo_d    = bus.lo_val;
          hi_d    = bus.hi_val;
          and_d   = bus.lo_val & bus.hi_val;
          i_d     = '0;
          j_d     = '0;
          state_d = (lim_cap != '0) ? FILL_LO : DONE;
        end
      end
      FILL_LO: begin
        fill_we  = 1'b1;
        fill_val = lo_q;
        if (j_q == j_max) begin
          j_d = '0;
          if (i_q + IW'(1) == lim_q) begin
            i_d     = '0;
            state_d = FILL_HI;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      FILL_HI: begin
        fill_we  = 1'b1;
        fill_val = hi_q;
        if (j_q == COLS_M1) begin
          // Rows at or beyond COLS have no upper-triangle words, so the fill ends there too.
          if ((i_q + IW'(1) >= lim_q) || (i_q + IW'(1) >= COLS_I)) begin
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
            j_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == FILL_LO) || (state_d == FILL_HI);
    done_d   = (state_d == DONE);
    wr_err_d = bus.wr_en && !host_ok;
  end

  // Host writes only happen in IDLE and fill writes never do, so one write port suffices.
  always_comb begin
    mem_we    = fill_we || (bus.wr_en && host_ok);
    mem_row   = fill_we ? i_q : IW'(bus.wr_row);
    mem_col   = fill_we ? j_q : IW'(bus.wr_col);
    mem_wdata = fill_we ? fill_val : bus.wr_data;
  end

  always_comb begin
    rd_data_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((IW'(r) == IW'(bus.rd_row)) && (IW'(c) == IW'(bus.rd_col))) rd_data_d = mem_q[r][c];
      end
    end
  end

  // NOTE: this array must clear on reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) mem_q[r][c] <= '0;
      end
    end else if (mem_we) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if ((IW'(r) == mem_row) && (IW'(c) == mem_col)) mem_q[r][c] <= mem_wdata;
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      lim_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      and_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      lim_q     <= lim_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      and_q     <= and_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.and_out = and_q;
  assign bus.wr_err  = wr_err_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_tri_fill_array.sv
// Directed bench for tri_fill_array: fills, clamping, host writes, reads and reset abort,
// with hand-computed expectations checked by immediate assertions.
module tb_tri_fill_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycles;

  always #5 clk = ~clk;

  tri_fill_if #(.WIDTH(8), .ROWS(16), .COLS(16)) bus ();

  tri_fill_array #(.WIDTH(8), .ROWS(16), .COLS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input int r, input int c, input logic [31:0] exp);
    bus.rd_row = r[3:0];
    bus.rd_col = c[3:0];
    @(negedge clk);
    check(tag, 32'(bus.rd_data), exp);
  endtask

  task automatic start_fill(input int lim, input logic [7:0] lo, input logic [7:0] hi);
    bus.start   = 1'b1;
    bus.row_lim = lim[4:0];
    bus.lo_val  = lo;
    bus.hi_val  = hi;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Counts negedges with busy high; a stuck busy stops at the budget and fails the count check.
  task automatic wait_fill(output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.row_lim = '0; bus.lo_val = '0; bus.hi_val = '0;
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
    bus.rd_row = '0; bus.rd_col = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 'h0);
    check("rst_done", 32'(bus.done), 'h0);
    check("rst_wr_err", 32'(bus.wr_err), 'h0);
    check("rst_and_out", 32'(bus.and_out), 'h0);
    check("rst_rd_data", 32'(bus.rd_data), 'h0);
    rst_n = 1'b1;
    rd_check("rst_rd_0_0", 0, 0, 'h0);
    rd_check("rst_rd_15_15", 15, 15, 'h0);

    // Fill 7 rows: 28 lower + 91 upper cycles
    start_fill(7, 8'hA5, 8'h3C);
    wait_fill(cycles);
    check("f7_busy_cycles", cycles, 119);
    check("f7_done", 32'(bus.done), 'h1);
    check("f7_and_out", 32'(bus.and_out), 'h24);
    @(negedge clk);
    check("f7_done_one_cycle", 32'(bus.done), 'h0);
    rd_check("f7_3_1", 3, 1, 'hA5);
    rd_check("f7_3_3", 3, 3, 'h3C);
    rd_check("f7_6_15", 6, 15, 'h3C);
    rd_check("f7_0_0", 0, 0, 'h3C);
    rd_check("f7_7_0", 7, 0, 'h00);
    rd_check("f7_6_0", 6, 0, 'hA5);

    // row_lim = 0: straight to DONE, no writes
    start_fill(0, 8'h0F, 8'h3C);
    check("z_busy", 32'(bus.busy), 'h0);
    check("z_done", 32'(bus.done), 'h1);
    check("z_and_out", 32'(bus.and_out), 'h0C);
    @(negedge clk);
    check("z_done_low", 32'(bus.done), 'h0);
    rd_check("z_3_1", 3, 1, 'hA5);
    rd_check("z_0_0", 0, 0, 'h3C);

    // row_lim = 20 clamps to 16: 136 + 136 cycles, whole array covered
    start_fill(20, 8'h01, 8'h02);
    wait_fill(cycles);
    check("c_busy_cycles", cycles, 272);
    check("c_done", 32'(bus.done), 'h1);
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        rd_check($sformatf("c_sweep_%0d_%0d", r, c), r, c, (c < r) ? 'h01 : 'h02);
      end
    end

    // Host write and a second start during FILL_HI are both rejected
    start_fill(3, 8'h30, 8'h21);
    repeat (7) @(negedge clk);
    check("h_busy", 32'(bus.busy), 'h1);
    bus.wr_en = 1'b1; bus.wr_row = 4'd2; bus.wr_col = 4'd2; bus.wr_data = 8'hFF;
    bus.start = 1'b1; bus.row_lim = 5'd9; bus.lo_val = 8'hEE; bus.hi_val = 8'h77;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    check("h_wr_err_pulse", 32'(bus.wr_err), 'h1);
    @(negedge clk);
    check("h_wr_err_clear", 32'(bus.wr_err), 'h0);
    wait_fill(cycles);
    check("h_busy_rest", cycles, 51 - 9);
    check("h_done", 32'(bus.done), 'h1);
    check("h_and_out", 32'(bus.and_out), 'h20);
    @(negedge clk);
    rd_check("h_2_2", 2, 2, 'h21);
    rd_check("h_1_0", 1, 0, 'h30);
    rd_check("h_3_0", 3, 0, 'h01);

    // Same-edge host write and start in IDLE: both happen
    bus.wr_en = 1'b1; bus.wr_row = 4'd5; bus.wr_col = 4'd9; bus.wr_data = 8'h77;
    start_fill(3, 8'h44, 8'h55);
    bus.wr_en = 1'b0;
    check("s_wr_err", 32'(bus.wr_err), 'h0);
    check("s_busy", 32'(bus.busy), 'h1);
    wait_fill(cycles);
    check("s_busy_cycles", cycles, 51);
    check("s_done", 32'(bus.done), 'h1);
    @(negedge clk);
    rd_check("s_5_9", 5, 9, 'h77);
    rd_check("s_2_5", 2, 5, 'h55);
    rd_check("s_2_1", 2, 1, 'h44);

    // Reset in the middle of FILL_LO aborts without a done pulse
    start_fill(16, 8'h99, 8'h66);
    repeat (20) @(negedge clk);
    check("r_busy_before", 32'(bus.busy), 'h1);
    rst_n = 1'b0;
    #1;
    check("r_busy_async", 32'(bus.busy), 'h0);
    check("r_and_out_async", 32'(bus.and_out), 'h0);
    check("r_rd_data_async", 32'(bus.rd_data), 'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cycles++;
    end
    check("r_no_done", cycles, 0);
    rd_check("r_0_0", 0, 0, 'h0);
    rd_check("r_5_9", 5, 9, 'h0);
    rd_check("r_3_1", 3, 1, 'h0);
    rd_check("r_15_15", 15, 15, 'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
